// File: rtl/sr_sie_scheduler_pkg.sv
// Shared SR package: FSM state codes and Q14 constants used by the SIE
// scheduler and the harmonic bank.
//   sie_state_e : scheduler state encoding (IDLE..REFRACT, 6/7 illegal)
//   Q14_ONE     : unity gain in Q14 (16384)
//   Q14_ZERO    : zero gain
package sr_sie_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_ONSET   = 3'd2,
      ST_PLATEAU = 3'd3,
      ST_DECAY   = 3'd4,
      ST_REFRACT = 3'd5
   } sie_state_e;

   localparam int Q14_ONE  = 16384;
   localparam int Q14_ZERO = 0;

endpackage

// File: rtl/sr_sie_scheduler_if.sv
// Scheduler bus: harmonic-bank flags in, ignition envelope and event status out.
//   sie_per_harmonic : per-harmonic coherence-and-beta-quiet flags
//   beta_quiet       : beta below quiet threshold
//   envelope         : signed Q14 ignition gain, 0..16384
//   lead_mask        : one-hot leading harmonic during an event
//   state            : current scheduler state code
//   event_active     : high in ONSET, PLATEAU, DECAY
//   event_count      : completed events, saturating
// master = harmonic bank / consumer side, slave = scheduler.
interface sr_sie_scheduler_if #(
   parameter int WIDTH         = 18,
   parameter int NUM_HARMONICS = 5
);
   logic [NUM_HARMONICS-1:0] sie_per_harmonic;
   logic                     beta_quiet;
   logic signed [WIDTH-1:0]  envelope;
   logic [NUM_HARMONICS-1:0] lead_mask;
   logic [2:0]               state;
   logic                     event_active;
   logic [15:0]              event_count;

   modport master (
      output sie_per_harmonic, beta_quiet,
      input  envelope, lead_mask, state, event_active, event_count
   );

   modport slave (
      input  sie_per_harmonic, beta_quiet,
      output envelope, lead_mask, state, event_active, event_count
   );
endinterface

// File: rtl/sr_sie_scheduler_envelope_ramp.sv
// sie_envelope_ramp: saturating up/down envelope ramp.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : tick strobe; level only moves on ticks
//   clr        : force level to zero (state recovery)
//   up, down   : ramp direction for this tick (up has priority)
//   step       : per-tick increment/decrement
//   level      : registered envelope, 0..TOP_LEVEL
//   hit_top    : this up-step reaches/saturates at TOP_LEVEL
//   hit_floor  : this down-step reaches/saturates at zero
module sie_envelope_ramp
   import sr_sie_scheduler_pkg::*;
#(
   parameter int WIDTH     = 18,
   parameter int TOP_LEVEL = Q14_ONE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             up,
   input  logic             down,
   input  logic [WIDTH-1:0] step,
   output logic [WIDTH-1:0] level,
   output logic             hit_top,
   output logic             hit_floor
);

   localparam logic [WIDTH:0]   TOP_W   = (WIDTH+1)'(TOP_LEVEL);
   localparam logic [WIDTH-1:0] TOP_L   = WIDTH'(TOP_LEVEL);
   localparam logic [WIDTH-1:0] FLOOR_L = WIDTH'(Q14_ZERO);

   logic [WIDTH-1:0] level_r;
   logic [WIDTH-1:0] next_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;

   // One extra bit of headroom so neither the sum nor the difference can wrap.
   always_comb begin
      sum_s     = {1'b0, level_r} + {1'b0, step};
      diff_s    = {1'b0, level_r} - {1'b0, step};
      hit_top   = (sum_s >= TOP_W);
      hit_floor = diff_s[WIDTH] || (diff_s == {(WIDTH+1){1'b0}});
      next_s    = level_r;
      if (up) begin
         if (hit_top) begin
            next_s = TOP_L;
         end else begin
            next_s = sum_s[WIDTH-1:0];
         end
      end else if (down) begin
         if (hit_floor) begin
            next_s = FLOOR_L;
         end else begin
            next_s = diff_s[WIDTH-1:0];
         end
      end else begin
         next_s = level_r;
      end
   end

   // Envelope register: cleared on reset or recovery, updated on ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_r <= FLOOR_L;
      end else if (clr) begin
         level_r <= FLOOR_L;
      end else if (en) begin
         level_r <= next_s;
      end else begin
         level_r <= level_r;
      end
   end

   assign level = level_r;

endmodule

// File: rtl/sr_sie_scheduler.sv
// sr_sie_scheduler: SIE ignition event scheduler. Debounces the harmonic
// bank's qualify condition, arms on the leading harmonic, ramps an ignition
// envelope up, holds it, ramps it down and enforces a refractory period.
//   clk, rst_n : system clock, asynchronous active-low reset
//   clk_en     : 4 kHz sample strobe; everything advances only on ticks
//   bus        : scheduler bus (slave side), see sr_sie_scheduler_if
module sr_sie_scheduler
   import sr_sie_scheduler_pkg::*;
#(
   parameter int WIDTH         = 18,
   parameter int FRAC          = 14,
   parameter int NUM_HARMONICS = 5,
   parameter int DEBOUNCE      = 8,
   parameter int RAMP_STEP     = 512,
   parameter int PLATEAU_MAX   = 4000,
   parameter int DROPOUT       = 16,
   parameter int REFRACT       = 2000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   sr_sie_scheduler_if.slave bus
);

   // Unity gain comes from the package for the Q14 build.
   localparam int               CEIL_Q  = (FRAC == 14) ? Q14_ONE : int'(32'd1 << FRAC);
   localparam logic [WIDTH-1:0] STEP_C  = WIDTH'(RAMP_STEP);
   localparam logic [15:0]      DEB_C   = 16'(DEBOUNCE);
   localparam logic [15:0]      PMAX_C  = 16'(PLATEAU_MAX);
   localparam logic [15:0]      DROP_C  = 16'(DROPOUT);
   localparam logic [15:0]      REF_C   = 16'(REFRACT);
   localparam logic [NUM_HARMONICS-1:0] NO_LEAD = {NUM_HARMONICS{1'b0}};

   sie_state_e               state_r;
   logic [15:0]              cnt_r;
   logic [15:0]              drop_r;
   logic [15:0]              evcnt_r;
   logic [NUM_HARMONICS-1:0] lead_r;
   logic                     active_r;

   logic [NUM_HARMONICS-1:0] sie_s;
   logic                     beta_s;
   logic                     qualify_s;
   logic                     illegal_s;
   logic                     up_s;
   logic                     down_s;
   logic                     hit_top_s;
   logic                     hit_floor_s;
   logic [WIDTH-1:0]         level_s;

   // Isolate the lowest set bit: v & (-v).
   function automatic logic [NUM_HARMONICS-1:0] lowest_one(input logic [NUM_HARMONICS-1:0] v);
      return v & (~v + {{(NUM_HARMONICS-1){1'b0}}, 1'b1});
   endfunction

   // Qualify decode, illegal-code detect and ramp direction.
   always_comb begin
      sie_s     = bus.sie_per_harmonic;
      beta_s    = bus.beta_quiet;
      qualify_s = (|sie_s) && beta_s;
      illegal_s = (state_r > ST_REFRACT);
      up_s      = 1'b0;
      down_s    = 1'b0;
      if (state_r == ST_ONSET) begin
         // a beta-loss tick leaves ONSET without stepping the envelope
         up_s = beta_s;
      end else if (state_r == ST_DECAY) begin
         down_s = 1'b1;
      end else begin
         up_s   = 1'b0;
         down_s = 1'b0;
      end
   end

   sie_envelope_ramp #(
      .WIDTH     (WIDTH),
      .TOP_LEVEL (CEIL_Q)
   ) u_ramp (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (clk_en),
      .clr       (illegal_s),
      .up        (up_s),
      .down      (down_s),
      .step      (STEP_C),
      .level     (level_s),
      .hit_top   (hit_top_s),
      .hit_floor (hit_floor_s)
   );

   // Scheduler FSM with its counters and registered status outputs.
   // cnt_r is shared: debounce run in IDLE, plateau length, refractory length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 16'd0;
         drop_r   <= 16'd0;
         evcnt_r  <= 16'd0;
         lead_r   <= NO_LEAD;
         active_r <= 1'b0;
      end else if (illegal_s) begin
         // codes 6/7 recover on the next clk, tick or not
         state_r  <= ST_IDLE;
         cnt_r    <= 16'd0;
         drop_r   <= 16'd0;
         lead_r   <= NO_LEAD;
         active_r <= 1'b0;
      end else if (clk_en) begin
         case (state_r)
            ST_IDLE: begin
               if (!qualify_s) begin
                  cnt_r <= 16'd0;
               end else if ((cnt_r + 16'd1) == DEB_C) begin
                  state_r <= ST_ARM;
                  cnt_r   <= 16'd0;
                  lead_r  <= lowest_one(sie_s);
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_ARM: begin
               if (qualify_s) begin
                  state_r  <= ST_ONSET;
                  active_r <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  lead_r  <= NO_LEAD;
               end
            end
            ST_ONSET: begin
               if (!beta_s) begin
                  state_r <= ST_DECAY;
               end else if (hit_top_s) begin
                  state_r <= ST_PLATEAU;
                  cnt_r   <= 16'd0;
                  drop_r  <= 16'd0;
               end else begin
                  state_r <= ST_ONSET;
               end
            end
            ST_PLATEAU: begin
               cnt_r <= cnt_r + 16'd1;
               if (qualify_s) begin
                  drop_r <= 16'd0;
               end else begin
                  drop_r <= drop_r + 16'd1;
               end
               if (!beta_s || ((cnt_r + 16'd1) == PMAX_C) ||
                   (!qualify_s && ((drop_r + 16'd1) == DROP_C))) begin
                  state_r <= ST_DECAY;
               end else begin
                  state_r <= ST_PLATEAU;
               end
            end
            ST_DECAY: begin
               // inputs are irrelevant here: reaching zero always goes to REFRACT
               if (hit_floor_s) begin
                  state_r  <= ST_REFRACT;
                  cnt_r    <= 16'd0;
                  lead_r   <= NO_LEAD;
                  active_r <= 1'b0;
                  if (evcnt_r != 16'hFFFF) begin
                     evcnt_r <= evcnt_r + 16'd1;
                  end else begin
                     evcnt_r <= evcnt_r;
                  end
               end else begin
                  state_r <= ST_DECAY;
               end
            end
            ST_REFRACT: begin
               if ((cnt_r + 16'd1) == REF_C) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 16'd0;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               cnt_r    <= 16'd0;
               drop_r   <= 16'd0;
               lead_r   <= NO_LEAD;
               active_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.envelope     = level_s;
   assign bus.lead_mask    = lead_r;
   assign bus.state        = state_r;
   assign bus.event_active = active_r;
   assign bus.event_count  = evcnt_r;

endmodule

// File: tb/tb_sr_sie_scheduler.sv
// Self-checking bench for sr_sie_scheduler: directed scenarios plus a long
// randomized run, all compared tick by tick against a behavioural model.
module tb_sr_sie_scheduler;

   localparam int WIDTH = 18;
   localparam int NH    = 5;
   localparam int DEB   = 8;
   localparam int STEP  = 512;
   localparam int PMAX  = 4000;
   localparam int DROP  = 16;
   localparam int REF   = 2000;
   localparam int ONE   = 16384;

   logic clk;
   logic rst_n;
   logic clk_en;

   sr_sie_scheduler_if #(.WIDTH(WIDTH), .NUM_HARMONICS(NH)) bus ();

   sr_sie_scheduler #(
      .WIDTH(WIDTH), .FRAC(14), .NUM_HARMONICS(NH), .DEBOUNCE(DEB),
      .RAMP_STEP(STEP), .PLATEAU_MAX(PMAX), .DROPOUT(DROP), .REFRACT(REF)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model: phase names as ints, counters as plain integers
   int m_state;
   int m_env;
   int m_run;
   int m_ticks;
   int m_miss;
   int m_left;
   int m_lead;
   int m_events;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_env = 0; m_run = 0; m_ticks = 0;
      m_miss = 0; m_left = 0; m_lead = 0; m_events = 0;
   endtask

   task automatic model_step(input logic [NH-1:0] sie, input bit bq);
      bit q;
      bit found;
      q = (sie != '0) && bq;
      case (m_state)
         0: begin
            m_run = q ? m_run + 1 : 0;
            if (m_run == DEB) begin
               m_state = 1;
               m_run   = 0;
               found   = 0;
               for (int i = 0; i < NH; i++) begin
                  if (!found && sie[i]) begin
                     m_lead = 1 << i;
                     found  = 1;
                  end
               end
            end
         end
         1: begin
            if (q) m_state = 2;
            else begin m_state = 0; m_lead = 0; end
         end
         2: begin
            if (!bq) m_state = 4;
            else begin
               m_env = (m_env + STEP > ONE) ? ONE : m_env + STEP;
               if (m_env == ONE) begin m_state = 3; m_ticks = 0; m_miss = 0; end
            end
         end
         3: begin
            m_ticks++;
            m_miss = q ? 0 : m_miss + 1;
            if (!bq || m_ticks == PMAX || m_miss == DROP) m_state = 4;
         end
         4: begin
            m_env = (m_env < STEP) ? 0 : m_env - STEP;
            if (m_env == 0) begin
               m_state  = 5;
               m_left   = REF;
               m_lead   = 0;
               m_events = (m_events < 65535) ? m_events + 1 : 65535;
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) begin m_state = 0; m_run = 0; end
         end
      endcase
   endtask

   task automatic compare_all();
      check_val("state",        32'(bus.state),        m_state);
      check_val("envelope",     32'(bus.envelope),     m_env);
      check_val("lead_mask",    32'(bus.lead_mask),    m_lead);
      check_val("event_active", 32'(bus.event_active), (m_state >= 2 && m_state <= 4) ? 1 : 0);
      check_val("event_count",  32'(bus.event_count),  m_events);
   endtask

   // one clk: drive on negedge, model the tick, sample 1 after posedge
   task automatic tick(input bit en, input logic [NH-1:0] sie, input bit bq);
      @(negedge clk);
      clk_en = en;
      bus.sie_per_harmonic = sie;
      bus.beta_quiet = bq;
      @(posedge clk);
      if (en) model_step(sie, bq);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clk_en = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst_n = 1'b1;
   endtask

   task automatic run_ticks(input int n, input logic [NH-1:0] sie, input bit bq);
      for (int i = 0; i < n; i++) tick(1'b1, sie, bq);
   endtask

   initial begin
      rst_n = 1'b0;
      clk_en = 1'b0;
      bus.sie_per_harmonic = '0;
      bus.beta_quiet = 1'b0;
      model_reset();

      // arm/onset timing, then plateau runs to its maximum length
      do_reset();
      check_val("reset_state", 32'(bus.state), 0);
      check_val("reset_env", 32'(bus.envelope), 0);
      run_ticks(7, 5'b00100, 1'b1);
      check_val("idle_tick7", 32'(bus.state), 0);
      run_ticks(1, 5'b00100, 1'b1);
      check_val("arm_tick8", 32'(bus.state), 1);
      check_val("arm_lead", 32'(bus.lead_mask), 4);
      run_ticks(1, 5'b00100, 1'b1);
      check_val("onset_tick9", 32'(bus.state), 2);
      run_ticks(31, 5'b00100, 1'b1);
      check_val("onset_31", 32'(bus.envelope), 15872);
      check_val("onset_31_state", 32'(bus.state), 2);
      run_ticks(1, 5'b00100, 1'b1);
      check_val("onset_32_env", 32'(bus.envelope), 16384);
      check_val("plateau_entry", 32'(bus.state), 3);
      run_ticks(PMAX - 1, 5'b00100, 1'b1);
      check_val("plateau_3999", 32'(bus.state), 3);
      run_ticks(1, 5'b00100, 1'b1);
      check_val("plateau_max_exit", 32'(bus.state), 4);
      run_ticks(32, 5'b00100, 1'b1);
      check_val("decay_done_state", 32'(bus.state), 5);
      check_val("decay_done_count", 32'(bus.event_count), 1);

      // a single miss restarts the debounce run
      do_reset();
      run_ticks(7, 5'b01000, 1'b1);
      run_ticks(1, 5'b00000, 1'b1);
      run_ticks(7, 5'b01000, 1'b1);
      check_val("miss_state", 32'(bus.state), 0);
      check_val("miss_env", 32'(bus.envelope), 0);

      // beta loss at plateau tick 100, full decay and refractory
      do_reset();
      run_ticks(41, 5'b00010, 1'b1);
      run_ticks(99, 5'b00010, 1'b1);
      run_ticks(1, 5'b00010, 1'b0);
      check_val("beta_drop_state", 32'(bus.state), 4);
      run_ticks(31, 5'b00010, 1'b0);
      check_val("decay_31_env", 32'(bus.envelope), 512);
      run_ticks(1, 5'b00010, 1'b0);
      check_val("refract_entry", 32'(bus.state), 5);
      check_val("refract_env", 32'(bus.envelope), 0);
      check_val("refract_count", 32'(bus.event_count), 1);
      check_val("refract_lead", 32'(bus.lead_mask), 0);
      run_ticks(REF - 1, 5'b11111, 1'b1);
      check_val("refract_1999", 32'(bus.state), 5);
      run_ticks(1, 5'b11111, 1'b1);
      check_val("refract_exit", 32'(bus.state), 0);

      // lowest set bit leads and stays latched
      do_reset();
      run_ticks(8, 5'b10110, 1'b1);
      check_val("lead_arm", 32'(bus.lead_mask), 2);
      run_ticks(6, 5'b10100, 1'b1);
      check_val("lead_held", 32'(bus.lead_mask), 2);
      check_val("lead_held_state", 32'(bus.state), 2);

      // dropout: 16 consecutive misses end the plateau
      do_reset();
      run_ticks(41, 5'b00001, 1'b1);
      run_ticks(15, 5'b00000, 1'b1);
      check_val("dropout_15", 32'(bus.state), 3);
      run_ticks(1, 5'b00000, 1'b1);
      check_val("dropout_16", 32'(bus.state), 4);
      run_ticks(4, 5'b00000, 1'b1);

      // asynchronous reset mid-onset
      do_reset();
      run_ticks(25, 5'b00100, 1'b1);
      check_val("mid_onset_env", 32'(bus.envelope), 8192);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_state", 32'(bus.state), 0);
      check_val("async_env", 32'(bus.envelope), 0);
      check_val("async_lead", 32'(bus.lead_mask), 0);
      check_val("async_active", 32'(bus.event_active), 0);
      check_val("async_count", 32'(bus.event_count), 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_ticks(1, 5'b00100, 1'b1);
      check_val("post_reset_idle", 32'(bus.state), 0);

      // randomized traffic with gaps in the tick strobe
      do_reset();
      for (int i = 0; i < 20000; i++) begin
         bit en;
         logic [NH-1:0] sie;
         bit bq;
         en  = ($urandom_range(0, 3) != 0);
         sie = ($urandom_range(0, 99) < 85) ? NH'($urandom_range(1, 31)) : '0;
         bq  = ($urandom_range(0, 99) >= 2);
         tick(en, sie, bq);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
